// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped I/O register bank.
// Register indices correspond to the one-hot select bit from the address
// decoder (I/O addresses IO_BASE..IO_BASE+7 map to select bits 0..7).
package io_pkg;

  localparam int          IO_DW   = 8;
  localparam int unsigned IO_BASE = 248;

  typedef enum logic [2:0] {
    IO_POUT0 = 3'd0,
    IO_POUT1 = 3'd1,
    IO_POUT2 = 3'd2,
    IO_POUT3 = 3'd3,
    IO_PIN0  = 3'd4,
    IO_PIN1  = 3'd5,
    IO_ISR   = 3'd6,
    IO_IMR   = 3'd7
  } io_reg_e;

  // True when exactly one select bit is set.
  function automatic logic io_sel_valid(input logic [7:0] sel);
    return (sel != '0) && ((sel & (sel - 8'd1)) == '0);
  endfunction

  // Index of the set bit; only meaningful when io_sel_valid() is true.
  function automatic io_reg_e io_sel_index(input logic [7:0] sel);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (sel[i]) idx = idx | 3'(i);
    end
    return io_reg_e'(idx);
  endfunction

endpackage

// File: rtl/io_sync.sv
// Two-flop synchronizer for an asynchronous input bus.
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset (clears both stages)
//   d     - asynchronous input
//   q     - synchronized output (second stage)
module io_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped I/O register bank: four output ports, two synchronized
// input ports, and an optional rising-edge interrupt on input port 0.
// Optional feature macro: IO_PORT_IRQ_EN (ISR/IMR, edge detect, irq).
// Ports:
//   clk, rst_n    - clock, synchronous active-low reset
//   io_sel        - one-hot register select (bit i -> register i)
//   we, re        - write / read strobes, qualified by a valid io_sel
//   DI            - write data
//   DO            - registered read data (0 when no valid read)
//   pout0..pout3  - output port registers
//   pin0, pin1    - asynchronous input ports
//   irq           - registered interrupt request (0 when feature absent)
module io_port_bank
  import io_pkg::*;
#(
  parameter int DW = IO_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    io_sel,
  input  logic          we,
  input  logic          re,
  input  logic [DW-1:0] DI,
  output logic [DW-1:0] DO,
  output logic [DW-1:0] pout0,
  output logic [DW-1:0] pout1,
  output logic [DW-1:0] pout2,
  output logic [DW-1:0] pout3,
  input  logic [DW-1:0] pin0,
  input  logic [DW-1:0] pin1,
  output logic          irq
);

  logic          sel_ok;
  io_reg_e       sel_idx;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] pin0_s;
  logic [DW-1:0] pin1_s;
  logic [DW-1:0] rdata;

  assign sel_ok  = io_sel_valid(io_sel);
  assign sel_idx = io_sel_index(io_sel);
  assign wr_en   = we && sel_ok;
  assign rd_en   = re && sel_ok;

  io_sync #(.W(DW)) u_sync_pin0 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pin0),
    .q     (pin0_s)
  );

  io_sync #(.W(DW)) u_sync_pin1 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pin1),
    .q     (pin1_s)
  );

`ifdef IO_PORT_IRQ_EN
  logic [DW-1:0] isr;
  logic [DW-1:0] imr;
  logic [DW-1:0] pin0_s3;
  logic [DW-1:0] edge_det;
  logic [DW-1:0] isr_clr;

  assign edge_det = pin0_s & ~pin0_s3;
  assign isr_clr  = (wr_en && sel_idx == IO_ISR) ? DI : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pin0_s3 <= '0;
      isr     <= '0;
      imr     <= '0;
      irq     <= 1'b0;
    end else begin
      pin0_s3 <= pin0_s;
      // Edge is OR-ed in after the clear so a same-cycle set wins.
      isr     <= (isr & ~isr_clr) | edge_det;
      if (wr_en && sel_idx == IO_IMR) imr <= DI;
      irq     <= |(isr & imr);
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Read mux reflects pre-write values, so a simultaneous write/read
  // returns the old contents.
  always_comb begin
    rdata = '0;
    case (sel_idx)
      IO_POUT0: rdata = pout0;
      IO_POUT1: rdata = pout1;
      IO_POUT2: rdata = pout2;
      IO_POUT3: rdata = pout3;
      IO_PIN0:  rdata = pin0_s;
      IO_PIN1:  rdata = pin1_s;
`ifdef IO_PORT_IRQ_EN
      IO_ISR:   rdata = isr;
      IO_IMR:   rdata = imr;
`endif
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pout0 <= '0;
      pout1 <= '0;
      pout2 <= '0;
      pout3 <= '0;
      DO    <= '0;
    end else begin
      if (wr_en) begin
        case (sel_idx)
          IO_POUT0: pout0 <= DI;
          IO_POUT1: pout1 <= DI;
          IO_POUT2: pout2 <= DI;
          IO_POUT3: pout3 <= DI;
          default:  ;
        endcase
      end
      DO <= rd_en ? rdata : '0;
    end
  end

endmodule

// File: tb/tb_io_port_bank.sv
module tb_io_port_bank;
  import io_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] io_sel;
  logic       we;
  logic       re;
  logic [7:0] DI;
  logic [7:0] DO;
  logic [7:0] pout0, pout1, pout2, pout3;
  logic [7:0] pin0, pin1;
  logic       irq;

  int checks;
  int failures;

  io_port_bank #(.DW(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_sel (io_sel),
    .we     (we),
    .re     (re),
    .DI     (DI),
    .DO     (DO),
    .pout0  (pout0),
    .pout1  (pout1),
    .pout2  (pout2),
    .pout3  (pout3),
    .pin0   (pin0),
    .pin1   (pin1),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: registers plus a history of pin values sampled at
  // past clock edges (p0_h[n] = pin0 sampled n edges ago).
  logic [7:0] m_pout [4];
  logic [7:0] m_isr, m_imr, m_do;
  logic       m_irq;
  logic [7:0] p0_h [1:3];
  logic [7:0] p1_h [1:2];
  bit         m_live = 0;

  always @(posedge clk) begin
    logic [7:0] sel, din, rv, clr, evt, p0, p1;
    logic       w, r, ok;
    int         idx;
    sel = io_sel; din = DI; w = we; r = re; p0 = pin0; p1 = pin1;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_pout[i] = 8'h00;
      m_isr = 0; m_imr = 0; m_do = 0; m_irq = 0;
      for (int i = 1; i <= 3; i++) p0_h[i] = 0;
      for (int i = 1; i <= 2; i++) p1_h[i] = 0;
      m_live = 1;
    end else if (m_live) begin
      ok  = ($countones(sel) == 1);
      idx = 0;
      for (int i = 0; i < 8; i++) if (sel[i]) idx = i;
      // What the core sees now: pin values from two edges ago.
      case (idx)
        0, 1, 2, 3: rv = m_pout[idx];
        4: rv = p0_h[2];
        5: rv = p1_h[2];
`ifdef IO_PORT_IRQ_EN
        6: rv = m_isr;
        7: rv = m_imr;
`endif
        default: rv = 0;
      endcase
      m_do = (r && ok) ? rv : 8'h00;
`ifdef IO_PORT_IRQ_EN
      evt   = p0_h[2] & ~p0_h[3];
      clr   = (w && ok && idx == 6) ? din : 8'h00;
      m_irq = |(m_isr & m_imr);
      m_isr = (m_isr & ~clr) | evt;
      if (w && ok && idx == 7) m_imr = din;
`else
      evt = 0; clr = 0;
`endif
      if (w && ok && idx < 4) m_pout[idx] = din;
      p0_h[3] = p0_h[2]; p0_h[2] = p0_h[1]; p0_h[1] = p0;
      p1_h[2] = p1_h[1]; p1_h[1] = p1;
    end
    if (m_live) begin
      #1;
      chk("m_pout0", pout0, m_pout[0]);
      chk("m_pout1", pout1, m_pout[1]);
      chk("m_pout2", pout2, m_pout[2]);
      chk("m_pout3", pout3, m_pout[3]);
      chk("m_DO", DO, m_do);
      chk("m_irq", {7'd0, irq}, {7'd0, m_irq});
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    we = 0; re = 0; io_sel = 8'h00; DI = 8'h00;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 0; pin0 = 0; pin1 = 0;
    idle();
    repeat (3) cyc();
    rst_n = 1;
    cyc();
    chk("rst_pout0", pout0, 8'h00);
    chk("rst_pout2", pout2, 8'h00);
    chk("rst_DO", DO, 8'h00);
    chk("rst_irq", {7'd0, irq}, 8'h00);

    // Basic write then read back.
    io_sel = 8'h04; we = 1; DI = 8'hA5;
    cyc();
    chk("wr_pout2", pout2, 8'hA5);
    chk("wr_pout0", pout0, 8'h00);
    chk("wr_pout3", pout3, 8'h00);
    we = 0; re = 1;
    cyc();
    chk("rd_pout2", DO, 8'hA5);
    re = 0;
    cyc();
    chk("rd_idle", DO, 8'h00);

    // Multi-hot select: write ignored, read zero.
    io_sel = 8'h03; we = 1; DI = 8'hFF;
    cyc();
    chk("multi_pout0", pout0, 8'h00);
    chk("multi_pout1", pout1, 8'h00);
    chk("multi_pout2", pout2, 8'hA5);
    we = 0; re = 1;
    cyc();
    chk("multi_rd", DO, 8'h00);

    // Write to a read-only input port is ignored; simultaneous read
    // returns the synchronized pin value (still 0).
    io_sel = 8'h10; we = 1; re = 1; DI = 8'h77;
    cyc();
    chk("pin0_ro", DO, 8'h00);
    idle();

    // Simultaneous write/read of pout3 returns the pre-write value.
    io_sel = 8'h08; we = 1; DI = 8'h5C;
    cyc();
    DI = 8'hC3; re = 1;
    cyc();
    chk("wr_rd_old", DO, 8'h5C);
    chk("wr_rd_new", pout3, 8'hC3);
    idle();

`ifndef IO_PORT_IRQ_EN
    io_sel = 8'h40; we = 1; DI = 8'hFF; cyc();
    io_sel = 8'h80; cyc();
    we = 0; re = 1; io_sel = 8'h40; cyc();
    chk("isr_absent", DO, 8'h00);
    io_sel = 8'h80; cyc();
    chk("imr_absent", DO, 8'h00);
    idle();
`endif

    // Input latency: pin0 changes before edge k.
    pin0 = 8'h5A; io_sel = 8'h10; re = 1;
    cyc();                       // edge k
    chk("pin_lat_k", DO, 8'h00);
    cyc();                       // edge k+1
    chk("pin_lat_k1", DO, 8'h00);
    cyc();                       // edge k+2
    chk("pin_lat_k2", DO, 8'h5A);
    idle();

`ifndef IO_PORT_IRQ_EN
    for (int i = 0; i < 8; i++) begin
      pin0 = (i % 2 == 0) ? 8'hFF : 8'h00;
      cyc();
      chk("irq_tied", {7'd0, irq}, 8'h00);
    end
`else
    // Clear accumulated flags, enable bit 0 only.
    pin0 = 8'h00;
    repeat (4) cyc();
    io_sel = 8'h40; we = 1; DI = 8'hFF; cyc();
    io_sel = 8'h80; DI = 8'h01; cyc();
    idle();
    repeat (2) cyc();
    pin0 = 8'h01;
    cyc();                       // k
    cyc();                       // k+1
    cyc();                       // k+2
    chk("irq_k2", {7'd0, irq}, 8'h00);
    io_sel = 8'h40; re = 1;
    cyc();                       // k+3
    chk("irq_k3", {7'd0, irq}, 8'h01);
    chk("isr_k2", DO, 8'h01);
    re = 0; we = 1; DI = 8'h01;
    cyc();                       // clear edge
    chk("irq_clr0", {7'd0, irq}, 8'h01);
    idle();
    cyc();
    chk("irq_clr1", {7'd0, irq}, 8'h00);
    chk("held_once", {7'd0, irq}, 8'h00);

    // Set wins over clear on the same edge.
    pin0 = 8'h00;
    repeat (3) cyc();
    pin0 = 8'h01;
    cyc();                       // k'
    cyc();                       // k'+1
    io_sel = 8'h40; we = 1; DI = 8'h01;
    cyc();                       // k'+2: edge and clear together
    we = 0; re = 1;
    cyc();
    chk("set_wins", DO, 8'h01);
    idle();
`endif

    // Reset during a write.
    io_sel = 8'h02; we = 1; DI = 8'h11; cyc();
    rst_n = 0; DI = 8'h3C;
    cyc();
    chk("rstw_pout1", pout1, 8'h00);
    chk("rstw_irq", {7'd0, irq}, 8'h00);
    rst_n = 1; we = 0; re = 1; io_sel = 8'h40;
    cyc();
    chk("rstw_isr", DO, 8'h00);
    idle();

    // Randomized traffic checked by the model every cycle.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(99) < 80) io_sel = 8'(1) << $urandom_range(7);
      else                         io_sel = 8'($urandom);
      we = $urandom_range(1);
      re = $urandom_range(1);
      DI = 8'($urandom);
      if ($urandom_range(3) == 0) pin0 = 8'($urandom);
      if ($urandom_range(3) == 0) pin1 = 8'($urandom);
      rst_n = ($urandom_range(99) != 0);
      cyc();
    end
    rst_n = 1;
    idle();
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_port_bank.md
# io_port_bank

Memory-mapped I/O register bank fed by the address decoder's one-hot I/O select lines (addresses 248–255 map to select bits 0–7). It holds four output port registers and two synchronized input ports. It also holds an interrupt status/mask pair that flags rising edges on input port 0 and drives a single `irq` line to the core. All register accesses complete in one clock, and read data is registered.

## Interface
- `DW`, 8, data/port width
- `clk` input 1: single system clock; all state changes on rising edge
- `rst_n` input 1: synchronous, active-low reset
- `io_sel` input 8: one-hot I/O select from the address decoder; bit i selects register i
- `we` input 1: write strobe, qualified by `io_sel`
- `re` input 1: read strobe, qualified by `io_sel`
- `DI` input DW: write data from core
- `DO` output DW: registered read data
- `pout0`..`pout3` output DW each: output port registers
- `pin0`, `pin1` input DW each: asynchronous external inputs
- `irq` output 1: registered interrupt request, active-high level

## Operation
- Register map by select bit:
  - 0–3: `pout0`–`pout3`, read/write.
  - 4: synchronized `pin0`, read-only.
  - 5: synchronized `pin1`, read-only.
  - 6: `ISR`, edge status; read returns the flags, write-1-to-clear.
  - 7: `IMR`, interrupt mask, read/write.
- Valid access requires `io_sel` to have exactly one bit set.
- Zero or multiple bits set:
  - writes are ignored;
  - a read returns 0.
- Writes to registers 4 and 5 are ignored.
- `we` and `re` both high in the same cycle:
  - the write takes effect;
  - `DO` returns the pre-write value.
- Reads have no side effects. `ISR` is not cleared by reading.
- Input path: each `pin` bit passes through a 2-flop synchronizer, giving s1 and s2.
  - `pin0` feeds a third flop, s3, used for edge detection.
  - `edge[i] = s2[i] & ~s3[i]`.
- ISR update each cycle: `ISR <= (ISR & ~clr) | edge`.
  - `clr` is `DI` when register 6 is validly written, else 0.
  - If set and clear hit the same bit in the same cycle, set wins.
- `irq <= |(ISR & IMR)`, evaluated on the current ISR and IMR values.
- Reset values, applied on `rst_n` low at a clock edge:
  - `pout0`–`pout3` = 0, `ISR` = 0, `IMR` = 0, `DO` = 0, `irq` = 0;
  - all synchronizer flops = 0.
- Reset asserted mid-operation overrides any write in the same cycle.

## Timing
- Write:
  - data is applied at the edge where `we` and a valid `io_sel` are sampled;
  - the `pout` value is visible immediately after that edge.
- Read:
  - `DO` is valid after the edge where `re` and a valid `io_sel` are sampled;
  - when `re` is low, `DO` = 0 the following cycle.
- Input latency for a `pin0` bit that changes before edge k:
  - s1 updates at k, s2 at k+1;
  - a read issued in the cycle after k+1 returns the new value;
  - on a rising transition, ISR bit sets at edge k+2;
  - `irq` rises at edge k+3 if the mask bit is set.
- Setting an `IMR` bit while the matching `ISR` bit is set raises `irq` one edge after the `IMR` write.
- Clearing `ISR` drops `irq` one edge after the clear.
- A `pin0` bit held high raises exactly one edge event.
- Pulses shorter than one clock period may be missed; this is by design.

## Configuration
- `IO_PORT_IRQ_EN` defined:
  - ISR, IMR, the s3 flops, edge detection and `irq` are present, as described above.
- Not defined:
  - registers 6 and 7 read 0;
  - writes to registers 6 and 7 are ignored;
  - `irq` is tied to 0;
  - no edge-detect flops are built;
  - the `pin0`/`pin1` synchronizers remain.

## Structure
- Shared package `io_pkg`:
  - register index constants `IO_POUT0`..`IO_POUT3`, `IO_PIN0`, `IO_PIN1`, `IO_ISR`, `IO_IMR`;
  - `IO_DW` = 8;
  - I/O base address 248.
- Sub-module `io_sync`: parameterised-width 2-flop synchronizer with synchronous active-low reset, instantiated once per input port.
- Everything else lives in the top module: one-hot validity check, read mux, register file and ISR logic.

## Test plan
- Reset, then write 8'hA5 with `io_sel`=8'h04 and `we`=1 → `pout2`=8'hA5 after the edge; other ports stay 0; read of select 8'h04 gives `DO`=8'hA5 one edge later.
- `io_sel`=8'h03 with `we`=1 and `DI`=8'hFF → no port changes. Read with the same select → `DO`=0.
- Drive `pin0`=8'h01 before edge k with `IMR`=8'h01 → ISR=8'h01 at k+2 and `irq`=1 at k+3. Write 8'h01 to ISR → `irq`=0 one edge after the clear.
- Edge on bit 0 in the same cycle as a write of 8'h01 to ISR → ISR bit 0 remains 1 (set wins).
- Assert `rst_n`=0 during a write of 8'h3C to `pout1` → `pout1`=0, ISR=0, `irq`=0 after the edge.
- Build without `IO_PORT_IRQ_EN` → reads of registers 6 and 7 return 0; `irq` stays 0 under `pin0` toggling; reads of `pin0` still track with 2-edge latency.
